// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream packet generator.
// Helpers work on a fixed maximum lane count; callers slice down to their own width.
package axis_pkg;

    typedef enum logic {IDLE, SEND} pktgen_state_t;

    localparam int unsigned MAX_BYTES = 128;

    // Low (len_lsbs + 1) lanes enabled.
    function automatic logic [MAX_BYTES-1:0] keep_mask(input int unsigned len_lsbs);
        logic [MAX_BYTES-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
            m[i] = (i <= len_lsbs);
        end
        return m;
    endfunction

    // Lane i = seed + base + i (8-bit wrap); lanes not in keep are zeroed.
    function automatic logic [MAX_BYTES*8-1:0] byte_pattern(input logic [7:0]           seed,
                                                            input logic [7:0]           base,
                                                            input logic [MAX_BYTES-1:0] keep);
        logic [MAX_BYTES*8-1:0] d;
        d = '0;
        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
            d[i*8 +: 8] = keep[i] ? (seed + base + 8'(i)) : 8'h00;
        end
        return d;
    endfunction

endpackage

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet transmitter: one command in, one incrementing-byte packet out.
// The output register doubles as the holding stage; the next beat loads only on handshake.
module axis_pkt_gen
    import axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned USER_WIDTH = 8,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    CMD_VALID,
    output logic                    CMD_READY,
    input  logic [LEN_WIDTH-1:0]    CMD_LEN,
    input  logic [ID_WIDTH-1:0]     CMD_ID,
    input  logic [USER_WIDTH-1:0]   CMD_USER,
    input  logic [7:0]              CMD_SEED,
    input  logic                    M_AXIS_TREADY,
    output logic                    M_AXIS_TVALID,
    output logic [DATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [USER_WIDTH-1:0]   M_AXIS_TUSER,
    output logic [ID_WIDTH-1:0]     M_AXIS_TID,
    output logic [DATA_WIDTH/8-1:0] M_AXIS_TKEEP,
    output logic                    M_AXIS_TLAST,
    output logic                    BUSY,
    output logic                    PKT_DONE,
    output logic [31:0]             PKT_CNT
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned LOG2B = $clog2(BYTES);
    localparam logic [BYTES-1:0]     KEEP_ALL = {BYTES{1'b1}};
    localparam logic [LEN_WIDTH-1:0] LSB_MASK = LEN_WIDTH'(BYTES - 1);

    pktgen_state_t         r_state,     w_state_nxt;
    logic                  r_tvalid,    w_tvalid_nxt;
    logic [DATA_WIDTH-1:0] r_tdata,     w_tdata_nxt;
    logic [BYTES-1:0]      r_tkeep,     w_tkeep_nxt;
    logic                  r_tlast,     w_tlast_nxt;
    logic [USER_WIDTH-1:0] r_tuser,     w_tuser_nxt;
    logic [ID_WIDTH-1:0]   r_tid,       w_tid_nxt;
    logic [7:0]            r_seed,      w_seed_nxt;
    logic [7:0]            r_offset,    w_offset_nxt;
    logic [LEN_WIDTH-1:0]  r_beat_cnt,  w_beat_cnt_nxt;
    logic [BYTES-1:0]      r_last_keep, w_last_keep_nxt;
    logic                  r_pkt_done;
    logic [31:0]           r_pkt_cnt;

    logic                   w_hs;
    logic                   w_last_hs;
    logic                   w_cmd_ready;
    logic                   w_cmd_acc;
    logic [LEN_WIDTH-1:0]   w_cmd_beats_m1;
    logic [LEN_WIDTH-1:0]   w_cmd_lsbs;
    logic [MAX_BYTES-1:0]   w_cmd_keep_wide;
    logic [BYTES-1:0]       w_cmd_keep;
    logic [7:0]             w_pat_seed;
    logic [7:0]             w_pat_off;
    logic [BYTES-1:0]       w_pat_keep;
    logic [MAX_BYTES*8-1:0] w_pat_wide;
    logic [DATA_WIDTH-1:0]  w_pat_data;

    assign w_hs        = r_tvalid & M_AXIS_TREADY;
    assign w_last_hs   = w_hs & r_tlast;
    // Ready again on the last-beat handshake so back-to-back packets have no bubble.
    assign w_cmd_ready = (r_state == IDLE) | w_last_hs;
    assign w_cmd_acc   = CMD_VALID & w_cmd_ready;

    assign w_cmd_beats_m1  = CMD_LEN >> LOG2B;
    assign w_cmd_lsbs      = CMD_LEN & LSB_MASK;
    assign w_cmd_keep_wide = keep_mask(32'(w_cmd_lsbs));
    assign w_cmd_keep      = w_cmd_keep_wide[BYTES-1:0];

    // Beat source: beat 0 of a new command, otherwise the beat after the current one.
    always_comb begin
        w_pat_seed = r_seed;
        w_pat_off  = r_offset + 8'(BYTES);
        w_pat_keep = (r_beat_cnt == LEN_WIDTH'(1)) ? r_last_keep : KEEP_ALL;
        if (w_cmd_acc) begin
            w_pat_seed = CMD_SEED;
            w_pat_off  = 8'h00;
            w_pat_keep = (w_cmd_beats_m1 == '0) ? w_cmd_keep : KEEP_ALL;
        end
    end

    assign w_pat_wide = byte_pattern(w_pat_seed, w_pat_off, MAX_BYTES'(w_pat_keep));
    assign w_pat_data = w_pat_wide[DATA_WIDTH-1:0];

    always_comb begin
        w_state_nxt     = r_state;
        w_tvalid_nxt    = r_tvalid;
        w_tdata_nxt     = r_tdata;
        w_tkeep_nxt     = r_tkeep;
        w_tlast_nxt     = r_tlast;
        w_tuser_nxt     = r_tuser;
        w_tid_nxt       = r_tid;
        w_seed_nxt      = r_seed;
        w_offset_nxt    = r_offset;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_last_keep_nxt = r_last_keep;
        if (w_cmd_acc) begin
            w_state_nxt     = SEND;
            w_tvalid_nxt    = 1'b1;
            w_seed_nxt      = CMD_SEED;
            w_offset_nxt    = 8'h00;
            w_beat_cnt_nxt  = w_cmd_beats_m1;
            w_last_keep_nxt = w_cmd_keep;
            w_tuser_nxt     = CMD_USER;
            w_tid_nxt       = CMD_ID;
            w_tlast_nxt     = (w_cmd_beats_m1 == '0);
            w_tkeep_nxt     = w_pat_keep;
            w_tdata_nxt     = w_pat_data;
        end else if (w_last_hs) begin
            w_state_nxt  = IDLE;
            w_tvalid_nxt = 1'b0;
            w_tdata_nxt  = '0;
            w_tkeep_nxt  = '0;
            w_tlast_nxt  = 1'b0;
            w_tuser_nxt  = '0;
            w_tid_nxt    = '0;
        end else if (w_hs) begin
            w_offset_nxt   = w_pat_off;
            w_beat_cnt_nxt = r_beat_cnt - LEN_WIDTH'(1);
            w_tlast_nxt    = (r_beat_cnt == LEN_WIDTH'(1));
            w_tkeep_nxt    = w_pat_keep;
            w_tdata_nxt    = w_pat_data;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= IDLE;
            r_tvalid    <= 1'b0;
            r_tdata     <= '0;
            r_tkeep     <= '0;
            r_tlast     <= 1'b0;
            r_tuser     <= '0;
            r_tid       <= '0;
            r_seed      <= '0;
            r_offset    <= '0;
            r_beat_cnt  <= '0;
            r_last_keep <= '0;
            r_pkt_done  <= 1'b0;
            r_pkt_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_tvalid    <= w_tvalid_nxt;
            r_tdata     <= w_tdata_nxt;
            r_tkeep     <= w_tkeep_nxt;
            r_tlast     <= w_tlast_nxt;
            r_tuser     <= w_tuser_nxt;
            r_tid       <= w_tid_nxt;
            r_seed      <= w_seed_nxt;
            r_offset    <= w_offset_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_last_keep <= w_last_keep_nxt;
            r_pkt_done  <= w_last_hs;
            r_pkt_cnt   <= r_pkt_cnt + 32'(w_last_hs);
        end
    end

    assign CMD_READY     = w_cmd_ready;
    assign M_AXIS_TVALID = r_tvalid;
    assign M_AXIS_TDATA  = r_tdata;
    assign M_AXIS_TKEEP  = r_tkeep;
    assign M_AXIS_TLAST  = r_tlast;
    assign M_AXIS_TUSER  = r_tuser;
    assign M_AXIS_TID    = r_tid;
    assign BUSY          = (r_state == SEND);
    assign PKT_DONE      = r_pkt_done;
    assign PKT_CNT       = r_pkt_cnt;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed bench for axis_pkt_gen at DATA_WIDTH=32; inputs driven and outputs sampled on negedge.
module tb_axis_pkt_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_len;
    logic [3:0]  cmd_id;
    logic [7:0]  cmd_user;
    logic [7:0]  cmd_seed;
    logic        tready;
    logic        tvalid;
    logic [31:0] tdata;
    logic [7:0]  tuser;
    logic [3:0]  tid;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        busy;
    logic        pkt_done;
    logic [31:0] pkt_cnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_cnt = 0;

    always #5 clk = ~clk;

    axis_pkt_gen #(
        .DATA_WIDTH(32), .USER_WIDTH(8), .ID_WIDTH(4), .LEN_WIDTH(16)
    ) dut (
        .CLK(clk), .RST_N(rst_n),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_LEN(cmd_len),
        .CMD_ID(cmd_id), .CMD_USER(cmd_user), .CMD_SEED(cmd_seed),
        .M_AXIS_TREADY(tready), .M_AXIS_TVALID(tvalid), .M_AXIS_TDATA(tdata),
        .M_AXIS_TUSER(tuser), .M_AXIS_TID(tid), .M_AXIS_TKEEP(tkeep), .M_AXIS_TLAST(tlast),
        .BUSY(busy), .PKT_DONE(pkt_done), .PKT_CNT(pkt_cnt)
    );

    task automatic drive_cmd(input logic [15:0] len, input logic [7:0] seed,
                             input logic [3:0] id, input logic [7:0] user);
        cmd_valid = 1'b1;
        cmd_len   = len;
        cmd_seed  = seed;
        cmd_id    = id;
        cmd_user  = user;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; cmd_id = '0; cmd_user = '0;
        cmd_seed = '0; tready = 1'b0;
        #3;
        checks++;
        if ({tvalid, tdata, tkeep, tlast, tid, tuser} !== '0) begin
            errors++;
            $display("FAIL reset_axis: got v=%b d=%h k=%h l=%b id=%h u=%h, want all 0",
                     tvalid, tdata, tkeep, tlast, tid, tuser);
        end
        checks++;
        if ({busy, pkt_done, pkt_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_status: got busy=%b done=%b cnt=%0d, want 0 0 0",
                     busy, pkt_done, pkt_cnt);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_single_beat;
        tready = 1'b1;
        drive_cmd(16'd2, 8'h10, 4'd3, 8'hA5);
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if ({tvalid, tdata, tkeep, tlast, tid, tuser, busy} !== {1'b1, 32'h00121110, 4'h7, 1'b1,
                                                               4'd3, 8'hA5, 1'b1}) begin
            errors++;
            $display("FAIL single_beat: got v=%b d=%h k=%h l=%b id=%h u=%h busy=%b, want 1 00121110 7 1 3 a5 1",
                     tvalid, tdata, tkeep, tlast, tid, tuser, busy);
        end
        @(negedge clk);
        exp_cnt++;
        checks++;
        if ({pkt_done, tvalid, busy} !== 3'b100 || pkt_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL single_done: got done=%b v=%b busy=%b cnt=%0d, want 1 0 0 %0d",
                     pkt_done, tvalid, busy, pkt_cnt, exp_cnt);
        end
        @(negedge clk);
        checks++;
        if (pkt_done !== 1'b0) begin
            errors++; $display("FAIL single_done_pulse: got %b want 0", pkt_done);
        end
    endtask

    task automatic test_multi_beat;
        logic [31:0] exp_d [3] = '{32'h0100FFFE, 32'h05040302, 32'h00000706};
        logic [3:0]  exp_k [3] = '{4'hF, 4'hF, 4'h3};
        tready = 1'b1;
        drive_cmd(16'd9, 8'hFE, 4'd5, 8'h11);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            checks++;
            if ({tvalid, tdata, tkeep, tlast} !== {1'b1, exp_d[b], exp_k[b], b == 2}) begin
                errors++;
                $display("FAIL multi_beat%0d: got v=%b d=%h k=%h l=%b, want 1 %h %h %b",
                         b, tvalid, tdata, tkeep, tlast, exp_d[b], exp_k[b], b == 2);
            end
            @(negedge clk);
        end
        exp_cnt++;
        checks++;
        if (tvalid !== 1'b0 || pkt_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL multi_end: got v=%b cnt=%0d, want 0 %0d", tvalid, pkt_cnt, exp_cnt);
        end
    endtask

    task automatic test_stall;
        tready = 1'b1;
        drive_cmd(16'd9, 8'hFE, 4'd6, 8'h22);
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (tdata !== 32'h0100FFFE) begin
            errors++; $display("FAIL stall_beat0: got %h want 0100fffe", tdata);
        end
        @(negedge clk);
        tready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if ({tvalid, tdata, tkeep, tlast, tid} !== {1'b1, 32'h05040302, 4'hF, 1'b0, 4'd6}) begin
                errors++;
                $display("FAIL stall_hold%0d: got v=%b d=%h k=%h l=%b id=%h, want 1 05040302 f 0 6",
                         k, tvalid, tdata, tkeep, tlast, tid);
            end
            if (k < 5) @(negedge clk);
        end
        tready = 1'b1;
        @(negedge clk);
        checks++;
        if ({tvalid, tdata, tkeep, tlast} !== {1'b1, 32'h00000706, 4'h3, 1'b1}) begin
            errors++;
            $display("FAIL stall_beat2: got v=%b d=%h k=%h l=%b, want 1 00000706 3 1",
                     tvalid, tdata, tkeep, tlast);
        end
        @(negedge clk);
        exp_cnt++;
        checks++;
        if (tvalid !== 1'b0 || pkt_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL stall_end: got v=%b cnt=%0d, want 0 %0d", tvalid, pkt_cnt, exp_cnt);
        end
    endtask

    task automatic test_back_to_back;
        tready = 1'b1;
        drive_cmd(16'd3, 8'h20, 4'd1, 8'h01);
        @(negedge clk);
        drive_cmd(16'd7, 8'h40, 4'd2, 8'h02);
        checks++;
        if ({tdata, tlast, cmd_ready} !== {32'h23222120, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL b2b_cmd1: got d=%h l=%b rdy=%b, want 23222120 1 1",
                     tdata, tlast, cmd_ready);
        end
        @(negedge clk);
        // Junk command while not ready must be ignored.
        drive_cmd(16'd0, 8'hEE, 4'd9, 8'h99);
        exp_cnt++;
        checks++;
        if ({tvalid, tdata, tlast, tid, pkt_done, cmd_ready} !==
            {1'b1, 32'h43424140, 1'b0, 4'd2, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_cmd2_beat0: got v=%b d=%h l=%b id=%h done=%b rdy=%b, want 1 43424140 0 2 1 0",
                     tvalid, tdata, tlast, tid, pkt_done, cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if ({tvalid, tdata, tkeep, tlast, tid} !== {1'b1, 32'h47464544, 4'hF, 1'b1, 4'd2}) begin
            errors++;
            $display("FAIL b2b_cmd2_beat1: got v=%b d=%h k=%h l=%b id=%h, want 1 47464544 f 1 2",
                     tvalid, tdata, tkeep, tlast, tid);
        end
        @(negedge clk);
        exp_cnt++;
        checks++;
        if (tvalid !== 1'b0 || pkt_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL b2b_end: got v=%b cnt=%0d, want 0 %0d", tvalid, pkt_cnt, exp_cnt);
        end
    endtask

    task automatic test_async_reset;
        tready = 1'b1;
        drive_cmd(16'd15, 8'h80, 4'd7, 8'h33);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (tdata !== 32'h8B8A8988) begin
            errors++; $display("FAIL areset_beat2: got %h want 8b8a8988", tdata);
        end
        #2 rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        checks++;
        if ({tvalid, busy, pkt_cnt} !== {1'b0, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL areset_assert: got v=%b busy=%b cnt=%0d, want 0 0 0", tvalid, busy, pkt_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmd_ready, tvalid} !== 2'b10) begin
            errors++;
            $display("FAIL areset_release: got rdy=%b v=%b, want 1 0", cmd_ready, tvalid);
        end
        drive_cmd(16'd1, 8'h55, 4'd4, 8'h44);
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if ({tvalid, tdata, tkeep, tlast, tid} !== {1'b1, 32'h00005655, 4'h3, 1'b1, 4'd4}) begin
            errors++;
            $display("FAIL areset_next_pkt: got v=%b d=%h k=%h l=%b id=%h, want 1 00005655 3 1 4",
                     tvalid, tdata, tkeep, tlast, tid);
        end
        @(negedge clk);
        exp_cnt++;
        checks++;
        if (pkt_cnt !== exp_cnt) begin
            errors++; $display("FAIL areset_cnt: got %0d want %0d", pkt_cnt, exp_cnt);
        end
    endtask

    task automatic test_long_packet;
        int          beats = 0;
        int          bad_keep = 0;
        int          early_last = 0;
        logic        done = 1'b0;
        logic [31:0] first_d = '0;
        logic [31:0] last_d = '0;
        tready = 1'b1;
        drive_cmd(16'hFFFF, 8'h00, 4'd8, 8'h55);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 20000 && !done; i++) begin
            if (tvalid) begin
                if (beats == 0) first_d = tdata;
                beats++;
                if (tkeep !== 4'hF) bad_keep++;
                if (tlast) begin
                    last_d = tdata;
                    done = 1'b1;
                    if (beats != 16384) early_last++;
                end
            end
            @(negedge clk);
        end
        checks++;
        if (!done) begin
            errors++; $display("FAIL long_timeout: got no TLAST after %0d beats, want 16384", beats);
        end
        checks++;
        if (beats != 16384 || early_last != 0) begin
            errors++; $display("FAIL long_beats: got %0d want 16384", beats);
        end
        checks++;
        if (bad_keep != 0) begin
            errors++; $display("FAIL long_keep: got %0d beats with TKEEP!=f, want 0", bad_keep);
        end
        checks++;
        if (first_d !== 32'h03020100 || last_d !== 32'hFFFEFDFC) begin
            errors++;
            $display("FAIL long_data: got first=%h last=%h, want 03020100 fffefdfc", first_d, last_d);
        end
        exp_cnt++;
        checks++;
        if (tvalid !== 1'b0 || pkt_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL long_end: got v=%b cnt=%0d, want 0 %0d", tvalid, pkt_cnt, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_multi_beat();
        test_stall();
        test_back_to_back();
        test_async_reset();
        test_long_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
